// File: rtl/demux_1to4_32bit_buffered_if.sv
// Producer/consumer signal bundle for the buffered 1-to-4 demultiplexer.
// The master drives the producer word and the consumer ready lines.
interface demux_1to4_32bit_buffered_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] IN;
  logic             IN_VALID;
  logic [1:0]       CONTROL;
  logic             IN_READY;
  logic [WIDTH-1:0] OP1;
  logic [WIDTH-1:0] OP2;
  logic [WIDTH-1:0] OP3;
  logic [WIDTH-1:0] OP4;
  logic [3:0]       OP_VALID;
  logic [3:0]       OP_READY;
  logic             BUSY;

  modport master (
    output IN, IN_VALID, CONTROL, OP_READY,
    input  IN_READY, OP1, OP2, OP3, OP4, OP_VALID, BUSY
  );

  modport slave (
    input  IN, IN_VALID, CONTROL, OP_READY,
    output IN_READY, OP1, OP2, OP3, OP4, OP_VALID, BUSY
  );
endinterface

// File: rtl/demux_1to4_32bit_buffered.sv
// Steers one producer word per cycle into one of four 2-entry FIFOs.
// Each FIFO drains independently to its consumer over valid/ready.
module demux_1to4_32bit_buffered #(
  parameter int WIDTH = 32
) (
  input logic                         CLK,
  input logic                         RST,
  demux_1to4_32bit_buffered_if.slave  bus
);

  logic [WIDTH-1:0] head_p0 [4];
  logic [WIDTH-1:0] tail_p0 [4];
  logic [1:0]       cnt_p0  [4];

  logic       in_ready;
  logic       push;
  logic [3:0] push_ch;
  logic [3:0] pop_ch;
  logic [3:0] op_valid;

  // IN_READY depends only on CONTROL and registered counts, never on OP_READY.
  always_comb begin
    in_ready = (cnt_p0[bus.CONTROL] != 2'd2);
    push     = bus.IN_VALID && in_ready;
    push_ch  = 4'b0000;
    pop_ch   = 4'b0000;
    op_valid = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      op_valid[n] = (cnt_p0[n] != 2'd0);
      push_ch[n]  = push && (bus.CONTROL == 2'(n));
      pop_ch[n]   = op_valid[n] && bus.OP_READY[n];
    end
  end

  // Stage p0: head and occupancy per channel
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < 4; n++) begin
        cnt_p0[n]  <= 2'd0;
        head_p0[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push_ch[n] && pop_ch[n]) begin
          // only reachable at cnt 1: the new word replaces the departing head
          head_p0[n] <= bus.IN;
        end else if (push_ch[n]) begin
          if (cnt_p0[n] == 2'd0) head_p0[n] <= bus.IN;
          cnt_p0[n] <= cnt_p0[n] + 2'd1;
        end else if (pop_ch[n]) begin
          if (cnt_p0[n] == 2'd2) head_p0[n] <= tail_p0[n];
          cnt_p0[n] <= cnt_p0[n] - 2'd1;
        end
      end
    end
  end

  // Tail is only read once cnt reaches 2, so it needs no reset.
  always_ff @(posedge CLK) begin
    for (int n = 0; n < 4; n++) begin
      if (push_ch[n] && !pop_ch[n] && (cnt_p0[n] == 2'd1)) tail_p0[n] <= bus.IN;
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.OP1      = head_p0[0];
  assign bus.OP2      = head_p0[1];
  assign bus.OP3      = head_p0[2];
  assign bus.OP4      = head_p0[3];
  assign bus.OP_VALID = op_valid;
  assign bus.BUSY     = |op_valid;

endmodule
